// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrclk/sdin in the clk domain and
// deserialises MSB-first words into left/right pairs with a valid strobe.
`timescale 1ns/1ps
module i2s_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             lrclk,
    input  logic             sdin,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             valid,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_lr_sync;
    logic [SYNC_STAGES-1:0] r_sd_sync;
    logic                   r_sclk_d;

    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] r_left;
    logic [WIDTH-1:0] r_right;
    logic [CW-1:0]    r_bitcnt;
    logic             r_lr_last;
    logic             r_left_ok;
    logic             r_done;
    logic             r_valid;
    logic             r_frame_err;

    logic w_sclk_s;
    logic w_lr_s;
    logic w_sd_s;
    logic w_rise;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_lr_s   = r_lr_sync[SYNC_STAGES-1];
    assign w_sd_s   = r_sd_sync[SYNC_STAGES-1];
    assign w_rise   = w_sclk_s & ~r_sclk_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync <= '0;
            r_lr_sync   <= '0;
            r_sd_sync   <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], lrclk};
            r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0], sdin};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_d    <= 1'b0;
            r_shreg     <= '0;
            r_hold      <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_bitcnt    <= '0;
            r_lr_last   <= 1'b0;
            r_left_ok   <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            if (w_rise) begin
                if (w_lr_s != r_lr_last) begin
                    // delay slot of the new channel; a partial word is dropped
                    if (r_bitcnt != '0 && r_bitcnt < CNT_FULL) begin
                        r_frame_err <= 1'b1;
                    end
                    r_bitcnt  <= '0;
                    r_lr_last <= w_lr_s;
                end else if (r_bitcnt < CNT_FULL) begin
                    r_shreg  <= {r_shreg[WIDTH-2:0], w_sd_s};
                    r_bitcnt <= r_bitcnt + CNT_ONE;
                    if (r_bitcnt == CNT_LAST) begin
                        r_done <= 1'b1;
                    end
                end
            end
            // sclk <= clk/4 guarantees no new shift lands in this cycle
            if (r_done) begin
                if (!r_lr_last) begin
                    r_hold    <= r_shreg;
                    r_left_ok <= 1'b1;
                end else if (r_left_ok) begin
                    r_left    <= r_hold;
                    r_right   <= r_shreg;
                    r_valid   <= 1'b1;
                    r_left_ok <= 1'b0;
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    assign left      = r_left;
    assign right     = r_right;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives I2S frames at sclk = clk/8 and checks
// outputs against a bit-queue reference of the receive rules.
`timescale 1ns/1ps
module tb_i2s_rx;

    localparam int W  = 16;
    localparam int SS = 2;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic         sclk  = 1'b0;
    logic         lrclk = 1'b1;
    logic         sdin  = 1'b0;
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic         valid;
    logic         frame_err;

    i2s_rx #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .sdin      (sdin),
        .left      (left),
        .right     (right),
        .valid     (valid),
        .frame_err (frame_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           t;
    } pair_t;

    bit           m_lr;
    bit           q[$];
    bit           m_lok;
    bit           m_err;
    logic [W-1:0] m_hold;
    pair_t        exp_q[$];
    int           vtimes[$];
    logic [W-1:0] last_l;
    logic [W-1:0] last_r;

    function automatic void model_reset();
        q.delete();
        m_lr   = 1'b0;
        m_lok  = 1'b0;
        m_err  = 1'b0;
        m_hold = '0;
        last_l = '0;
        last_r = '0;
    endfunction

    function automatic void model_rise(bit lr, bit d, int t);
        logic [W-1:0] w;
        if (lr != m_lr) begin
            if (q.size() > 0 && q.size() < W) m_err = 1'b1;
            q.delete();
            m_lr = lr;
            return;
        end
        if (q.size() >= W) return;
        q.push_back(d);
        if (q.size() == W) begin
            w = '0;
            for (int i = 0; i < W; i++) w[W-1-i] = q[i];
            if (!lr) begin
                m_hold = w;
                m_lok  = 1'b1;
            end else if (m_lok) begin
                exp_q.push_back('{m_hold, w, t});
                m_lok = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end
    endfunction

    always @(negedge clk) begin : mon
        pair_t p;
        if (!reset && valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", {31'b0, valid}, 32'd0);
            end else begin
                p = exp_q.pop_front();
                check("left", {16'b0, left}, {16'b0, p.l});
                check("right", {16'b0, right}, {16'b0, p.r});
                check("latency", cyc - p.t, SS + 2);
                vtimes.push_back(cyc);
                last_l = p.l;
                last_r = p.r;
            end
        end
    end

    task automatic send_bit(bit lr, bit d, bit do_rst);
        sclk  = 1'b0;
        lrclk = lr;
        sdin  = d;
        repeat (2) @(negedge clk);
        if (do_rst) begin
            reset = 1'b1;
            @(negedge clk);
            model_reset();
            check("rst_left", {16'b0, left}, 32'd0);
            check("rst_right", {16'b0, right}, 32'd0);
            check("rst_valid", {31'b0, valid}, 32'd0);
            reset = 1'b0;
            @(negedge clk);
        end else begin
            repeat (2) @(negedge clk);
        end
        sclk = 1'b1;
        model_rise(lr, d, cyc);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_slot(bit lr, logic [31:0] bits, int nd, int len,
                             int rst_at);
        bit d;
        for (int p = 0; p < len; p++) begin
            if (p >= 1 && p <= nd) d = bits[32-p];
            else d = 1'($urandom_range(0, 1));
            send_bit(lr, d, p == rst_at);
        end
    endtask

    task automatic frame(logic [W-1:0] l, logic [W-1:0] r);
        send_slot(1'b0, {l, 16'h0}, W, 32, -1);
        send_slot(1'b1, {r, 16'h0}, W, 32, -1);
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        sclk  = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        check("reset_left", {16'b0, left}, 32'd0);
        check("reset_right", {16'b0, right}, 32'd0);
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_err", {31'b0, frame_err}, 32'd0);
        reset = 1'b0;
        // single right-channel bit so streams begin on a right-to-left edge
        send_bit(1'b1, 1'b0, 1'b0);
    endtask

    task automatic settle(string tag);
        repeat (8) @(negedge clk);
        check({tag, "_pending"}, exp_q.size(), 32'd0);
        check({tag, "_err"}, {31'b0, frame_err}, {31'b0, m_err});
        check({tag, "_hold_l"}, {16'b0, left}, {16'b0, last_l});
        check({tag, "_hold_r"}, {16'b0, right}, {16'b0, last_r});
    endtask

    logic [15:0] b2b_l [4] = '{16'h0001, 16'h0002, 16'h0004, 16'h8000};
    logic [15:0] b2b_r [4] = '{16'hFFFF, 16'h0000, 16'h7FFF, 16'h8001};

    initial begin
        int nd, ll, lr_len;
        logic [W-1:0] rl, rr;
        @(negedge clk);

        hard_reset();
        frame(16'hA5C3, 16'h3C5A);
        settle("nominal");
        check("nom_left", {16'b0, left}, 32'h0000A5C3);
        check("nom_right", {16'b0, right}, 32'h00003C5A);

        vtimes.delete();
        for (int i = 0; i < 4; i++) frame(b2b_l[i], b2b_r[i]);
        settle("b2b");
        check("b2b_count", vtimes.size(), 32'd4);
        if (vtimes.size() == 4) begin
            for (int i = 1; i < 4; i++)
                check("b2b_gap", vtimes[i] - vtimes[i-1], 32'd512);
        end
        check("b2b_left", {16'b0, left}, 32'h00008000);
        check("b2b_right", {16'b0, right}, 32'h00008001);

        hard_reset();
        send_slot(1'b0, {16'h1234, 8'hFF, 8'h00}, 24, 32, -1);
        send_slot(1'b1, {16'hBEEF, 8'h00, 8'h00}, 24, 32, -1);
        settle("pad");
        check("pad_left", {16'b0, left}, 32'h00001234);
        check("pad_right", {16'b0, right}, 32'h0000BEEF);

        hard_reset();
        frame(16'h1111, 16'h2222);
        send_slot(1'b0, {16'h3333, 16'h0}, W, 32, -1);
        send_slot(1'b1, {16'h4444, 16'h0}, W, 32, 8);
        frame(16'h5555, 16'h6666);
        settle("rstmid");
        check("rstmid_left", {16'b0, left}, 32'h00005555);
        check("rstmid_right", {16'b0, right}, 32'h00006666);

        hard_reset();
        send_slot(1'b0, {16'hAAAA, 16'h0}, 10, 11, -1);
        send_slot(1'b1, {16'hBBBB, 16'h0}, W, 32, -1);
        settle("short");
        check("short_err_set", {31'b0, frame_err}, 32'd1);
        check("short_no_left", {16'b0, left}, 32'd0);
        frame(16'hCAFE, 16'hF00D);
        settle("after_short");
        check("short_err_sticky", {31'b0, frame_err}, 32'd1);
        check("after_short_left", {16'b0, left}, 32'h0000CAFE);
        check("after_short_right", {16'b0, right}, 32'h0000F00D);

        hard_reset();
        for (int f = 0; f < 10; f++) begin
            rl     = W'($urandom);
            rr     = W'($urandom);
            ll     = $urandom_range(W + 1, 32);
            lr_len = $urandom_range(W + 1, 32);
            nd     = W;
            if ($urandom_range(0, 4) == 0) begin
                nd = $urandom_range(1, W - 1);
                ll = nd + 1;
            end
            send_slot(1'b0, {rl, 16'h0}, nd, ll, -1);
            send_slot(1'b1, {rr, 16'h0}, W, lr_len, -1);
        end
        settle("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
